// File: rtl/day2_pipe_reg_if.sv
// Handshake bundle for day2_pipe_reg: producer side, consumer side,
// flush control and the registered occupancy count.
// The slave modport is the pipeline itself; the master modport is whoever
// drives it (producer and consumer together, e.g. a testbench).
`timescale 1ns/1ps

interface day2_pipe_reg_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             flush_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] in_data_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] out_data_o;
   logic [CNT_W-1:0] count_o;

   modport master (
      output flush_i,
      output in_valid_i,
      output in_data_i,
      output out_ready_i,
      input  in_ready_o,
      input  out_valid_o,
      input  out_data_o,
      input  count_o
   );

   modport slave (
      input  flush_i,
      input  in_valid_i,
      input  in_data_i,
      input  out_ready_i,
      output in_ready_o,
      output out_valid_o,
      output out_data_o,
      output count_o
   );

endinterface

// File: rtl/day2_pipe_reg.sv
// day2_pipe_reg: WIDTH-bit, DEPTH-stage register pipeline with valid/ready
// handshaking. Every stage advances on its own, so a stalled consumer makes
// empty stages collapse rather than freezing the whole chain.
//
// Optional feature macro: PIPE_DATA_RST_EN
//   defined   -> data registers clear to 0 on reset
//   undefined -> data registers carry no reset; only valid bits and count do
// Flush never touches the data registers in either build.
`timescale 1ns/1ps

module day2_pipe_reg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           reset,
   day2_pipe_reg_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_q;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [CNT_W-1:0] count_q;

   logic [DEPTH-1:0] move;
   logic [DEPTH-1:0] load;
   logic             full_above;
   logic             in_ready;
   logic             accept;

   // Stage k can move forward if the stage ahead is empty or is itself
   // moving; unrolled, that means some stage above k is empty or the
   // consumer is taking the head. Walking from the output end keeps this
   // free of a combinational loop through the move vector.
   always_comb begin
      move       = '0;
      full_above = 1'b1;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         move[k]    = v_q[k] && (bus.out_ready_i || !full_above);
         full_above = full_above && v_q[k];
      end
   end

   // Input side: stage 0 accepts when it is empty or draining, unless the
   // pipe is being discarded this cycle.
   always_comb begin
      in_ready = !reset && !bus.flush_i && (!v_q[0] || move[0]);
      accept   = bus.in_valid_i && in_ready;
   end

   // A stage is loaded either from the producer (stage 0) or from the stage
   // behind it when that stage moves.
   always_comb begin
      load    = '0;
      load[0] = accept;
      for (int k = 1; k < DEPTH; k++) begin
         load[k] = move[k-1];
      end
   end

   // Valid bits: set on load, cleared when the content leaves without a
   // replacement, all dropped on reset or flush.
   always_ff @(posedge clk) begin
      if (reset || bus.flush_i) begin
         v_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (load[k]) begin
               v_q[k] <= 1'b1;
            end else if (move[k]) begin
               v_q[k] <= 1'b0;
            end
         end
      end
   end

`ifdef PIPE_DATA_RST_EN
   // Data registers: cleared on reset, otherwise written only when loaded.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         if (load[0]) begin
            d_q[0] <= bus.in_data_i;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (load[k]) begin
               d_q[k] <= d_q[k-1];
            end
         end
      end
   end
`else
   // Data registers: no reset, written only when loaded so idle stages
   // never toggle. Consumers must qualify data with out_valid_o.
   always_ff @(posedge clk) begin
      if (load[0]) begin
         d_q[0] <= bus.in_data_i;
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (load[k]) begin
            d_q[k] <= d_q[k-1];
         end
      end
   end
`endif

   // Occupancy: one in per accept, one out per consumer handshake; a
   // simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk) begin
      if (reset || bus.flush_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(accept) - CNT_W'(move[DEPTH-1]);
      end
   end

   // The count must always match the number of occupied stages.
   assert property (@(posedge clk) disable iff (reset)
      count_q == CNT_W'($countones(v_q)));

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = v_q[DEPTH-1];
   assign bus.out_data_o  = d_q[DEPTH-1];
   assign bus.count_o     = count_q;

endmodule

// File: tb/tb_day2_pipe_reg.sv
// Testbench for day2_pipe_reg: a DEPTH=4 and a DEPTH=1 instance, each driven
// cycle by cycle. Accepted items go into a per-instance queue and are popped
// and compared on every consumer handshake; ready and count are checked each
// cycle against the queue occupancy.
`timescale 1ns/1ps

module tb_day2_pipe_reg;

   localparam int WIDTH = 8;

   logic clk;
   logic reset;

   int checks;
   int errors;

   logic [WIDTH-1:0] q4[$];
   logic [WIDTH-1:0] q1[$];

   logic             obs_valid;
   logic [WIDTH-1:0] obs_data;
   logic             obs_ready;
   int               obs_count;
   logic             obs_accept;

   day2_pipe_reg_if #(.WIDTH(WIDTH), .DEPTH(4)) if4 ();
   day2_pipe_reg_if #(.WIDTH(WIDTH), .DEPTH(1)) if1 ();

   day2_pipe_reg #(.WIDTH(WIDTH), .DEPTH(4)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4.slave)
   );

   day2_pipe_reg #(.WIDTH(WIDTH), .DEPTH(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // One cycle: drive the selected instance (the other idles), check ready,
   // count and any delivered item against the queue, update the queue, then
   // advance to the next negedge.
   task automatic applyStimulus(input bit sel1, input bit vld,
                                input logic [WIDTH-1:0] data, input bit rdy,
                                input bit flush, input bit rst);
      int depth;
      int qsize;
      logic [WIDTH-1:0] exp;

      reset = rst;
      if4.in_valid_i  = sel1 ? 1'b0 : vld;
      if4.in_data_i   = data;
      if4.out_ready_i = sel1 ? 1'b0 : rdy;
      if4.flush_i     = sel1 ? 1'b0 : flush;
      if1.in_valid_i  = sel1 ? vld : 1'b0;
      if1.in_data_i   = data;
      if1.out_ready_i = sel1 ? rdy : 1'b0;
      if1.flush_i     = sel1 ? flush : 1'b0;
      #1;

      depth     = sel1 ? 1 : 4;
      qsize     = sel1 ? q1.size() : q4.size();
      obs_valid = sel1 ? if1.out_valid_o : if4.out_valid_o;
      obs_data  = sel1 ? if1.out_data_o : if4.out_data_o;
      obs_ready = sel1 ? if1.in_ready_o : if4.in_ready_o;
      obs_count = sel1 ? int'(if1.count_o) : int'(if4.count_o);
      obs_accept = vld && obs_ready;

      checkOutput("count", obs_count, qsize);
      checkOutput("in_ready", obs_ready, !flush && !rst && (qsize < depth || rdy));
      if (qsize == 0) checkOutput("empty_out_valid", obs_valid, 1'b0);
      if (qsize == depth) checkOutput("full_out_valid", obs_valid, 1'b1);

      if (obs_valid && rdy && qsize > 0) begin
         if (sel1) exp = q1.pop_front();
         else      exp = q4.pop_front();
         checkOutput("out_data", obs_data, exp);
      end

      if (rst) begin
         q4.delete();
         q1.delete();
      end else if (flush) begin
         if (sel1) q1.delete();
         else      q4.delete();
      end else if (obs_accept) begin
         if (sel1) q1.push_back(data);
         else      q4.push_back(data);
      end

      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int first;
      int idx;
      int acc;
      logic [WIDTH-1:0] items [6];

      checks = 0;
      errors = 0;
      reset  = 1'b1;
      if4.in_valid_i = 1'b0; if4.in_data_i = '0; if4.out_ready_i = 1'b0; if4.flush_i = 1'b0;
      if1.in_valid_i = 1'b0; if1.in_data_i = '0; if1.out_ready_i = 1'b0; if1.flush_i = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Reset held two cycles with a pending input that must be ignored.
      applyStimulus(0, 1, 8'hAA, 1, 0, 1);
      applyStimulus(0, 1, 8'hAA, 1, 0, 1);
      applyStimulus(0, 0, 8'h00, 0, 0, 0);
      checkOutput("rst_out_valid", obs_valid, 1'b0);
      checkOutput("rst_in_ready", obs_ready, 1'b1);
      checkOutput("rst_count", obs_count, 0);
`ifdef PIPE_DATA_RST_EN
      checkOutput("rst_out_data", obs_data, 8'h00);
`endif

      // Streaming: 0x01..0x10 back to back with the consumer always ready.
      first = -1;
      for (int c = 0; c < 24; c++) begin
         applyStimulus(0, c < 16, WIDTH'(c + 1), 1, 0, 0);
         if (obs_valid && first < 0) first = c;
      end
      checkOutput("stream_latency", first, 4);
      checkOutput("stream_drained", q4.size(), 0);

      // Backpressure: six offered with the consumer stalled, then released.
      for (int i = 0; i < 6; i++) items[i] = WIDTH'(8'hB0 + i);
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(0, 1, items[idx], 0, 0, 0);
         if (obs_accept) idx++;
      end
      checkOutput("bp_accepted", idx, 4);
      checkOutput("bp_ready_low", obs_ready, 1'b0);
      for (int c = 0; c < 10 && idx < 6; c++) begin
         applyStimulus(0, 1, items[idx], 1, 0, 0);
         if (c == 0) checkOutput("bp_ready_release", obs_ready, 1'b1);
         if (obs_accept) idx++;
      end
      checkOutput("bp_all_accepted", idx, 6);
      for (int c = 0; c < 8; c++) applyStimulus(0, 0, 8'h00, 1, 0, 0);
      checkOutput("bp_drained", q4.size(), 0);

      // Bubble collapse: lone item, idle gap, then three more behind it.
      applyStimulus(0, 1, 8'h11, 0, 0, 0);
      for (int c = 0; c < 3; c++) applyStimulus(0, 0, 8'h00, 0, 0, 0);
      applyStimulus(0, 1, 8'h22, 0, 0, 0);
      applyStimulus(0, 1, 8'h33, 0, 0, 0);
      applyStimulus(0, 1, 8'h44, 0, 0, 0);
      applyStimulus(0, 0, 8'h00, 0, 0, 0);
      checkOutput("bubble_count", obs_count, 4);
      checkOutput("bubble_head", obs_data, 8'h11);
      for (int c = 0; c < 6; c++) applyStimulus(0, 0, 8'h00, 1, 0, 0);
      checkOutput("bubble_drained", q4.size(), 0);

      // Flush with three items in flight and an input offered in that cycle.
      applyStimulus(0, 1, 8'hA1, 0, 0, 0);
      applyStimulus(0, 1, 8'hA2, 0, 0, 0);
      applyStimulus(0, 1, 8'hA3, 0, 0, 0);
      applyStimulus(0, 1, 8'h55, 0, 1, 0);
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
      checkOutput("flush_count", obs_count, 0);
      checkOutput("flush_out_valid", obs_valid, 1'b0);
      for (int c = 0; c < 6; c++) applyStimulus(0, 0, 8'h00, 1, 0, 0);

      // DEPTH=1: accept and deliver every cycle, then reset mid-stream.
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1, 1, WIDTH'(8'h60 + c), 1, 0, 0);
         if (obs_accept) acc++;
      end
      checkOutput("d1_accepts", acc, 10);
      checkOutput("d1_count", obs_count, 1);
      applyStimulus(1, 1, 8'h70, 1, 0, 1);
      applyStimulus(1, 0, 8'h00, 1, 0, 0);
      checkOutput("d1_rst_count", obs_count, 0);
      for (int c = 0; c < 3; c++) applyStimulus(1, 0, 8'h00, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/day2_pipe_reg.md
# day2_pipe_reg

Parametrised register pipeline with valid/ready handshaking and bubble collapse. It generalises the single D flip-flop to WIDTH-bit data through DEPTH stages. Each stage advances independently, so stalls at the output compact empty stages instead of freezing the whole chain. It sits between any producer/consumer pair in the design that needs registered retiming, with an occupancy count and a synchronous flush.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 4: number of register stages, ≥1.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous discard of all pipeline contents.
- in_valid_i  input  1  producer has data.
- in_ready_o  output  1  pipeline accepts data this cycle.
- in_data_i  input  WIDTH  producer data.
- out_valid_o  output  1  last stage holds valid data.
- out_ready_i  input  1  consumer accepts data this cycle.
- out_data_o  output  WIDTH  last-stage data.
- count_o  output  $clog2(DEPTH+1)  number of valid stages, registered.

## Operation
- State per stage k (0 = input side, DEPTH-1 = output):
  - valid bit v[k];
  - data register d[k].
- Stage moves:
  - move[DEPTH-1] = v[DEPTH-1] && out_ready_i.
  - move[k] = v[k] && (!v[k+1] || move[k+1]) for k < DEPTH-1.
  - The ready chain is combinational from out_ready_i.
- in_ready_o = !flush_i && (!v[0] || move[0]).
- Input accept: in_valid_i && in_ready_o.
- On each edge, stage k+1 loads d[k] when move[k]. Stage 0 loads in_data_i on accept.
- v[k] next value:
  - set if the stage is loaded;
  - cleared if it moved out and was not reloaded;
  - otherwise held.
- Data registers update only when their stage is loaded. No data toggling otherwise.
- Output is the last stage: out_valid_o = v[DEPTH-1], out_data_o = d[DEPTH-1].
- count_o next = count_o + accept − move[DEPTH-1]. It never exceeds DEPTH and never underflows.
- Ordering is strictly FIFO. There is no duplication or loss except on flush/reset.
- Flush (flush_i=1):
  - Next cycle: all v[k]=0, count_o=0.
  - An input presented in the flush cycle is not accepted (in_ready_o=0).
  - An output handshake in the flush cycle counts as delivered to the consumer.
  - d[k] is not cleared.
- Reset (reset=1): same as flush for v[k], count_o and in_ready_o. Reset has priority over every other input. Data behaviour follows the Configuration section.
- Reset values:
  - out_valid_o=0, count_o=0.
  - in_ready_o=1 once reset and flush_i are low.
  - out_data_o per Configuration.

## Timing
- Latency: an item accepted at edge t appears on out_valid_o/out_data_o in the cycle after edge t+DEPTH−1. That is DEPTH cycles after the acceptance cycle into an empty pipe.
- Throughput: one item per cycle sustained when out_ready_i=1, for any DEPTH including 1.
- Full pipe (count_o=DEPTH):
  - with out_ready_i=1, in_ready_o=1 in the same cycle (simultaneous push and pop);
  - with out_ready_i=0, in_ready_o=0.
- Empty pipe: out_valid_o=0. There is no combinational input-to-output path for data or valid.
- Bubble collapse: with out_ready_i=0, a lone item reaches stage DEPTH-1 after DEPTH−1 further edges. Subsequent items then fill in behind it until count_o=DEPTH.
- Simultaneous accept and deliver: count_o unchanged.
- Reset or flush asserted mid-transfer: the in-flight state is discarded at that edge. Normal operation resumes in the next cycle.

## Configuration
- Macro: PIPE_DATA_RST_EN.
  - Defined: all d[k] reset to 0 on reset, so out_data_o=0 after reset. Flush still leaves data untouched.
  - Undefined: data registers have no reset; only valid bits and count reset. out_data_o is undefined (X in simulation) until the first item reaches the last stage. Consumers must qualify data with out_valid_o.

## Test plan
- Reset:
  - Stimulus: reset high 2 cycles with in_valid_i=1, in_data_i=0xAA.
  - Response: out_valid_o=0, count_o=0, in_ready_o=1 after release. No item delivered. out_data_o=0 with PIPE_DATA_RST_EN, X without.
- Streaming (DEPTH=4, WIDTH=8):
  - Stimulus: out_ready_i=1, back-to-back inputs 0x01..0x10 from cycle 0.
  - Response: first out_valid_o in cycle 4 with 0x01, then one item per cycle in order. in_ready_o stays 1; count_o=4 in steady state.
- Backpressure:
  - Stimulus: out_ready_i=0, offer 6 items.
  - Response: 4 accepted; in_ready_o drops after the 4th; count_o=4.
  - Then raise out_ready_i: in_ready_o=1 in that same cycle, and items 5 and 6 follow 1–4 in order.
- Bubble collapse:
  - Stimulus: out_ready_i=0, push 0x11, idle 3 cycles, then push 0x22, 0x33, 0x44.
  - Response: all accepted; count_o=4; output order 0x11, 0x22, 0x33, 0x44.
- Flush mid-stream:
  - Stimulus: count_o=3, flush_i=1 for one cycle with in_valid_i=1, in_data_i=0x55.
  - Response: next cycle count_o=0, out_valid_o=0; 0x55 and the flushed items are never output.
- DEPTH=1 corner:
  - Stimulus: full pipe with out_ready_i=1 and in_valid_i=1 every cycle.
  - Response: accept and deliver every cycle; count_o stays 1.
  - Mid-stream reset: count_o=0 on the next cycle.
